// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline-stage definitions: handshake FSM states and per-stage bundle widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Data bundles: operands, PC, immediate, PC+4 plus register indices.
    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 3 * XLEN;
    localparam int ID_EX_CTRL_W  = 10;
    localparam int ID_EX_DATA_W  = 5 * XLEN + 3 * REG_ADDR_W;
    localparam int EX_MEM_CTRL_W = 5;
    localparam int EX_MEM_DATA_W = 4 * XLEN + REG_ADDR_W;
    localparam int MEM_WB_CTRL_W = 3;
    localparam int MEM_WB_DATA_W = 3 * XLEN + REG_ADDR_W;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One storage entry (control + data) of the elastic stage; clear beats load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = ID_EX_CTRL_W,
    parameter int DATA_W     = ID_EX_DATA_W,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q
);

    logic [CTRL_W-1:0] ctrl_d;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clear) begin
            ctrl_d = '0;
            if (CLEAR_DATA != 0) data_d = '0;
        end else if (load) begin
            ctrl_d = ctrl_in;
            data_d = data_in;
        end
    end

    // Reset always zeroes data, even when clears leave it stale.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt / flush_cnt outputs.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = ID_EX_CTRL_W,
    parameter int DATA_W     = ID_EX_DATA_W,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    stage_state_t      state_q, state_d;
    logic              ready_q, ready_d;
    logic              in_fire, out_fire;
    logic              m_load, m_clear, m_from_s, s_load, s_clear;
    logic [CTRL_W-1:0] s_ctrl, m_ctrl_src;
    logic [DATA_W-1:0] s_data, m_data_src;

    assign in_fire  = valid_in & ready_q;
    assign out_fire = valid_out & ready_in;

    always_comb begin
        state_d  = state_q;
        m_load   = 1'b0;
        m_clear  = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        if (flush) begin
            state_d = EMPTY;
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: if (in_fire) begin
                    m_load  = 1'b1;
                    state_d = ONE;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_load = 1'b1;
                    end else if (in_fire) begin
                        s_load  = 1'b1;
                        state_d = TWO;
                    end else if (out_fire) begin
                        m_clear = 1'b1;
                        state_d = EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    m_load   = 1'b1;
                    m_from_s = 1'b1;
                    s_clear  = 1'b1;
                    state_d  = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
        ready_d = (state_d != TWO);
    end

    assign m_ctrl_src = m_from_s ? s_ctrl : ctrl_in;
    assign m_data_src = m_from_s ? s_data : data_in;

    // ready_q resets low and rises on the first edge after release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
        .clock   (clock),
        .reset   (reset),
        .load    (m_load),
        .clear   (m_clear),
        .ctrl_in (m_ctrl_src),
        .data_in (m_data_src),
        .ctrl_q  (ctrl_out),
        .data_q  (data_out)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .load    (s_load),
        .clear   (s_clear),
        .ctrl_in (ctrl_in),
        .data_in (data_in),
        .ctrl_q  (s_ctrl),
        .data_q  (s_data)
    );

    assign ready_out = ready_q;
    assign valid_out = (state_q != EMPTY);

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (valid_out && !ready_in)        stall_cnt_d = sat_inc(stall_cnt_q);
        if (flush && (state_q != EMPTY))   flush_cnt_d = sat_inc(flush_cnt_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
